pll_lock_supervisor: RTL

// - Sequences the clock PLL at power-up and on loss of lock. Pulses the PLL reset,

---
 rtl/pll_lock_supervisor_if.sv | 35 +++
 rtl/pll_lock_supervisor.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its surroundings.
// The supervisor connects through the slave modport; the environment
// (PLL wrapper, reset distribution, or a testbench) uses master.
interface pll_lock_supervisor_if;
    logic       locked;
    logic       retry_req;
    logic       pll_reset;
    logic       sys_reset_n;
    logic       ready;
    logic       fault;
    logic [7:0] lock_loss_count;
    logic [2:0] state_dbg;

    modport master (
        output locked,
        output retry_req,
        input  pll_reset,
        input  sys_reset_n,
        input  ready,
        input  fault,
        input  lock_loss_count,
        input  state_dbg
    );

    modport slave (
        input  locked,
        input  retry_req,
        output pll_reset,
        output sys_reset_n,
        output ready,
        output fault,
        output lock_loss_count,
        output state_dbg
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for lock with a timeout
// and bounded retries, requires a stable settle window, and only then
// releases the downstream system reset. Lock loss in RUN re-sequences the
// PLL and is counted (saturating). All outputs are registered decodes of
// the next state, so they line up with the state register exactly.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 3,
    parameter int CNT_W          = 16
) (
    input logic                  clock_in,
    input logic                  reset_n,
    pll_lock_supervisor_if.slave bus
);

    localparam logic [2:0] ST_RESET_PLL = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_SETTLE    = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAULT     = 3'd4;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

    logic [2:0]       state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic [7:0]       retries, retries_next;
    logic [7:0]       loss_count, loss_count_next;

    logic             sync_meta;
    logic             locked_s;

    logic             pll_reset_q;
    logic             sys_reset_n_q;
    logic             ready_q;
    logic             fault_q;

    // Two-flop synchronizer for the asynchronous lock flag; held clear while
    // the PLL is in reset so a stale lock cannot leak into the next attempt.
    always_ff @(posedge clock_in) begin
        if (!reset_n || pll_reset_q) begin
            sync_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            sync_meta <= bus.locked;
            locked_s  <= sync_meta;
        end
    end

    // Next-state, phase counter, retry and lock-loss bookkeeping.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_next      = state;
        count_next      = count;
        retries_next    = retries;
        loss_count_next = loss_count;

        case (state)
            ST_RESET_PLL: begin
                if (count == RST_LAST) begin
                    state_next = ST_WAIT_LOCK;
                    count_next = '0;
                end else begin
                    count_next = count + CNT_ONE;
                end
            end

            ST_WAIT_LOCK: begin
                // Lock wins over a coincident timeout.
                if (locked_s) begin
                    state_next = ST_SETTLE;
                    count_next = '0;
                end else if (count == TIMEOUT_LAST) begin
                    count_next = '0;
                    if (retries == RETRY_LIMIT) begin
                        state_next = ST_FAULT;
                    end else begin
                        retries_next = retries + 8'd1;
                        state_next   = ST_RESET_PLL;
                    end
                end else begin
                    count_next = count + CNT_ONE;
                end
            end

            ST_SETTLE: begin
                // Any drop restarts the lock wait with a fresh timeout;
                // this also covers a drop on the final settle cycle.
                if (!locked_s) begin
                    state_next = ST_WAIT_LOCK;
                    count_next = '0;
                end else if (count == SETTLE_LAST) begin
                    state_next   = ST_RUN;
                    count_next   = '0;
                    retries_next = '0;
                end else begin
                    count_next = count + CNT_ONE;
                end
            end

            ST_RUN: begin
                if (!locked_s) begin
                    if (loss_count != 8'hFF) begin
                        loss_count_next = loss_count + 8'd1;
                    end
                    state_next = ST_RESET_PLL;
                    count_next = '0;
                end
            end

            ST_FAULT: begin
                if (bus.retry_req) begin
                    state_next   = ST_RESET_PLL;
                    count_next   = '0;
                    retries_next = '0;
                end
            end

            default: begin
                state_next = ST_RESET_PLL;
                count_next = '0;
            end
        endcase
    end

    // State, counters and output registers; outputs decode the next state so
    // they change on the same edge as the state register.
    always_ff @(posedge clock_in) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values and the block order does not matter.
        if (!reset_n) begin
            state         <= ST_RESET_PLL;
            count         <= '0;
            retries       <= '0;
            loss_count    <= '0;
            pll_reset_q   <= 1'b1;
            sys_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            retries       <= retries_next;
            loss_count    <= loss_count_next;
            pll_reset_q   <= (state_next == ST_RESET_PLL) || (state_next == ST_FAULT);
            sys_reset_n_q <= (state_next == ST_RUN);
            ready_q       <= (state_next == ST_RUN);
            fault_q       <= (state_next == ST_FAULT);
        end
    end

    assign bus.pll_reset       = pll_reset_q;
    assign bus.sys_reset_n     = sys_reset_n_q;
    assign bus.ready           = ready_q;
    assign bus.fault           = fault_q;
    assign bus.lock_loss_count = loss_count;
    assign bus.state_dbg       = state;

endmodule
